dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port synchronous data RAM between two requesters. Port 0 is the processor load/store unit; port 1 is the debug/DMA loader. Arbitration is round-robin with optional locked bursts bounded by MAX_BURST. The block sits between the processor core and the data memory instance and owns the RAM enable, write and address lines.

Parameters:
RAM_WIDTH, 32, data word width in bits
RAM_ADDR_BITS, 9, word address width (512 words)
MAX_BURST, 4, max beats one requester may hold the RAM under lock (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request valid
req0_we  in  1  port 0 write (1) / read (0)
req0_lock  in  1  port 0 wants to keep the grant after this beat
req0_addr  in  RAM_ADDR_BITS  port 0 word address
req0_wdata  in  RAM_WIDTH  port 0 write data
req0_ready  out  1  port 0 beat accepted this cycle when valid&ready
rsp0_valid  out  1  port 0 read data valid
rsp0_rdata  out  RAM_WIDTH  port 0 read data
req1_* / rsp1_*  same as port 0, for port 1
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write strobe
ram_addr  out  RAM_ADDR_BITS  RAM address
ram_wdata  out  RAM_WIDTH  RAM write data
ram_rdata  in  RAM_WIDTH  RAM read data, valid one cycle after read strobe

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Registered priority pointer prio (0 or 1). Beat counter beat_cnt, ceil(log2(MAX_BURST+1)) bits.
- Reset values: state=IDLE, prio=0, beat_cnt=0, rsp0_valid=rsp1_valid=0. Both rsp*_rdata read 0.
- IDLE:
  - No ready asserted; RAM idle.
  - Only reqX_valid -> OWNX.
  - Both valid -> OWN[prio].
  - None valid -> stay in IDLE.
  - On entering OWNX: prio <= ~X, beat_cnt <= 0.
- OWNX, reqX_ready combinational:
  - reqX_ready = reqX_valid. The other port's ready = 0.
  - ram_en = reqX_valid&reqX_ready. ram_we/addr/wdata are driven from port X.
- Beat acceptance in OWNX (valid&ready): beat_cnt <= beat_cnt+1.
- Leave OWNX -> IDLE when any of:
  - accepted beat with reqX_lock=0;
  - accepted beat where beat_cnt+1 == MAX_BURST (forced release, lock ignored);
  - reqX_valid=0 during OWNX (no transfer that cycle).
- Otherwise stay in OWNX.
- Latency:
  - Request seen in IDLE is accepted on the next cycle.
  - Unlocked throughput per port is 1 beat per 2 cycles.
  - Locked burst is 1 beat per cycle.
- Ram outputs when ram_en=0: ram_we=0, ram_addr=0, ram_wdata=0.
- Read response:
  - Accepted read on port X -> rspX_valid=1 exactly one cycle later.
  - rspX_rdata = ram_rdata while rspX_valid, else 0.
  - Writes produce no response.
  - rsp0_valid and rsp1_valid are never both 1.
- Simultaneous events:
  - A response for the previous beat and a new acceptance may coincide.
  - A new request on the losing port while the winner holds the RAM waits. It is served no later than MAX_BURST+1 cycles after the current grant starts (starvation bound).
- Reset mid-burst:
  - Returns to IDLE next edge and clears pending rsp_valid.
  - An in-flight read response is dropped.
  - prio returns to 0.
- Requesters must hold valid/we/addr/wdata/lock stable until ready. Behaviour on violation is undefined.

Test Plan:
- Reset: assert reset 2 cycles with both valid=1 -> all ready=0, ram_en=0, rsp*_valid=0. After release, first grant goes to port 0 (prio=0).
- Single read: port0 read addr 5 (RAM[5]=0xDEADBEEF) -> ready=1 on cycle 2, ram_en=1/ram_we=0/addr=5. Cycle 3: rsp0_valid=1, rsp0_rdata=0xDEADBEEF.
- Round robin: both ports issue unlocked reads continuously -> grants alternate 0,1,0,1. Each accepted beat is followed by exactly one rsp on the matching port only.
- Locked burst: port1 writes addr 10..15 with lock=1, MAX_BURST=4, port0 read pending -> port1 writes 10..13 back-to-back, then port0 is granted, then port1 resumes at 14.
- Write-then-read: port1 writes 0x12345678 to addr 511, port0 then reads 511 -> rsp0_rdata=0x12345678. The write produces no rsp1_valid.
- Reset mid-burst: reset during port0 locked read burst, beat 2 -> next cycle state IDLE, rsp0_valid=0, no further ram_en until a new request.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one synchronous data RAM between two requesters
module dmem_arbiter #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 9,
    parameter int MAX_BURST     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    input  logic                     req0_we,
    input  logic                     req0_lock,
    input  logic [RAM_ADDR_BITS-1:0] req0_addr,
    input  logic [RAM_WIDTH-1:0]     req0_wdata,
    output logic                     req0_ready,
    output logic                     rsp0_valid,
    output logic [RAM_WIDTH-1:0]     rsp0_rdata,
    input  logic                     req1_valid,
    input  logic                     req1_we,
    input  logic                     req1_lock,
    input  logic [RAM_ADDR_BITS-1:0] req1_addr,
    input  logic [RAM_WIDTH-1:0]     req1_wdata,
    output logic                     req1_ready,
    output logic                     rsp1_valid,
    output logic [RAM_WIDTH-1:0]     rsp1_rdata,
    output logic                     ram_en,
    output logic                     ram_we,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [RAM_WIDTH-1:0]     ram_wdata,
    input  logic [RAM_WIDTH-1:0]     ram_rdata
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t        state;
    logic          prio;
    logic [BW-1:0] beat_cnt;
    logic          acc0, acc1, last_beat;

    // grant the owning port, steer its beat onto the RAM, zero the bus otherwise
    always_comb begin
        req0_ready = (state == OWN0) & req0_valid;
        req1_ready = (state == OWN1) & req1_valid;
        acc0       = req0_valid & req0_ready;
        acc1       = req1_valid & req1_ready;
        ram_en     = acc0 | acc1;
        ram_we     = acc0 ? req0_we : acc1 ? req1_we : 1'b0;
        ram_addr   = acc0 ? req0_addr : acc1 ? req1_addr : '0;
        ram_wdata  = acc0 ? req0_wdata : acc1 ? req1_wdata : '0;
        last_beat  = (beat_cnt + BW'(1)) == MAX_B;
        rsp0_rdata = rsp0_valid ? ram_rdata : '0;
        rsp1_rdata = rsp1_valid ? ram_rdata : '0;
    end

    // ownership FSM with priority pointer, burst counter and read-response flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prio       <= 1'b0;
            beat_cnt   <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            rsp0_valid <= acc0 & ~req0_we;
            rsp1_valid <= acc1 & ~req1_we;
            case (state)
                IDLE: begin
                    if (req0_valid && (!req1_valid || !prio)) begin
                        state    <= OWN0;
                        prio     <= 1'b1;
                        beat_cnt <= '0;
                    end else if (req1_valid) begin
                        state    <= OWN1;
                        prio     <= 1'b0;
                        beat_cnt <= '0;
                    end
                end
                OWN0: begin
                    if (acc0) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (!req0_lock || last_beat) state <= IDLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                OWN1: begin
                    if (acc1) begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (!req1_lock || last_beat) state <= IDLE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of arbitration, bursts, responses and reset
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_we, req0_lock, req0_ready, rsp0_valid;
    logic [8:0]  req0_addr;
    logic [31:0] req0_wdata, rsp0_rdata;
    logic        req1_valid, req1_we, req1_lock, req1_ready, rsp1_valid;
    logic [8:0]  req1_addr;
    logic [31:0] req1_wdata, rsp1_rdata;
    logic        ram_en, ram_we;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [31:0] mem [512];
    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.RAM_WIDTH(32), .RAM_ADDR_BITS(9), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // synchronous RAM model, refilled with a known pattern while reset is held
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem[5] <= 32'hDEADBEEF;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req0_we = 1'b0; req0_lock = 1'b0; req0_addr = 9'd1; req0_wdata = '0;
        req1_valid = 1'b1; req1_we = 1'b0; req1_lock = 1'b0; req1_addr = 9'd2; req1_wdata = '0;
        tick();
        chk("rst_ready0", {31'b0, req0_ready}, 0);
        chk("rst_ready1", {31'b0, req1_ready}, 0);
        chk("rst_ram_en", {31'b0, ram_en}, 0);
        tick();
        chk("rst_rsp0", {31'b0, rsp0_valid}, 0);
        chk("rst_rsp1", {31'b0, rsp1_valid}, 0);
        chk("rst_rdata0", rsp0_rdata, 0);
        chk("rst_rdata1", rsp1_rdata, 0);
        reset = 1'b0;
        settle();
        chk("idle_ram_en", {31'b0, ram_en}, 0);
        // round robin: port 0 wins first, then alternate
        tick();
        chk("rr_ready0_a", {31'b0, req0_ready}, 1);
        chk("rr_ready1_a", {31'b0, req1_ready}, 0);
        chk("rr_addr_a", {23'b0, ram_addr}, 1);
        tick();
        chk("rr_rsp0_a", {31'b0, rsp0_valid}, 1);
        chk("rr_rdata0_a", rsp0_rdata, 32'hA000_0001);
        chk("rr_rsp1_a", {31'b0, rsp1_valid}, 0);
        chk("rr_gap_en", {31'b0, ram_en}, 0);
        tick();
        chk("rr_ready1_b", {31'b0, req1_ready}, 1);
        chk("rr_ready0_b", {31'b0, req0_ready}, 0);
        chk("rr_addr_b", {23'b0, ram_addr}, 2);
        tick();
        chk("rr_rsp1_b", {31'b0, rsp1_valid}, 1);
        chk("rr_rdata1_b", rsp1_rdata, 32'hA000_0002);
        chk("rr_rsp0_b", {31'b0, rsp0_valid}, 0);
        tick();
        chk("rr_ready0_c", {31'b0, req0_ready}, 1);
        tick();
        req0_valid = 1'b0;
        settle();
        chk("rr_rsp0_c", {31'b0, rsp0_valid}, 1);
        tick();
        chk("rr_ready1_d", {31'b0, req1_ready}, 1);
        // single read of address 5
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 9'd5;
        settle();
        chk("rr_rsp1_d", {31'b0, rsp1_valid}, 1);
        chk("sr_idle_ready", {31'b0, req0_ready}, 0);
        tick();
        chk("sr_ready0", {31'b0, req0_ready}, 1);
        chk("sr_ram_en", {31'b0, ram_en}, 1);
        chk("sr_ram_we", {31'b0, ram_we}, 0);
        chk("sr_addr", {23'b0, ram_addr}, 5);
        tick();
        req0_valid = 1'b0;
        settle();
        chk("sr_rsp0", {31'b0, rsp0_valid}, 1);
        chk("sr_rdata0", rsp0_rdata, 32'hDEADBEEF);
        chk("sr_en_off", {31'b0, ram_en}, 0);
        // write 511 on port 1, then read it back on port 0
        tick();
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 9'd511; req1_wdata = 32'h12345678;
        tick();
        chk("wr_ready1", {31'b0, req1_ready}, 1);
        chk("wr_ram_we", {31'b0, ram_we}, 1);
        chk("wr_addr", {23'b0, ram_addr}, 511);
        chk("wr_wdata", ram_wdata, 32'h12345678);
        tick();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 9'd511;
        settle();
        chk("wr_no_rsp1", {31'b0, rsp1_valid}, 0);
        chk("wr_idle_wdata", ram_wdata, 0);
        tick();
        chk("wr_rd_ready0", {31'b0, req0_ready}, 1);
        tick();
        req0_valid = 1'b0;
        settle();
        chk("wr_rd_rsp0", {31'b0, rsp0_valid}, 1);
        chk("wr_rd_rdata0", rsp0_rdata, 32'h12345678);
        // locked burst on port 1 with port 0 read pending
        tick();
        req1_valid = 1'b1; req1_we = 1'b1; req1_lock = 1'b1; req1_addr = 9'd10; req1_wdata = 32'h10A;
        req0_valid = 1'b1; req0_addr = 9'd5;
        tick();
        chk("lb_ready1_10", {31'b0, req1_ready}, 1);
        chk("lb_ready0_10", {31'b0, req0_ready}, 0);
        chk("lb_addr_10", {23'b0, ram_addr}, 10);
        for (int a = 11; a <= 13; a++) begin
            tick();
            req1_addr = 9'(a); req1_wdata = 32'h100 + 32'(a);
            settle();
            chk("lb_ready1_burst", {31'b0, req1_ready}, 1);
            chk("lb_addr_burst", {23'b0, ram_addr}, 32'(a));
        end
        tick();
        req1_addr = 9'd14; req1_wdata = 32'h10E;
        settle();
        chk("lb_release_en", {31'b0, ram_en}, 0);
        tick();
        chk("lb_ready0", {31'b0, req0_ready}, 1);
        chk("lb_ready1_wait", {31'b0, req1_ready}, 0);
        chk("lb_addr_p0", {23'b0, ram_addr}, 5);
        tick();
        req0_valid = 1'b0;
        settle();
        chk("lb_rsp0", {31'b0, rsp0_valid}, 1);
        chk("lb_rdata0", rsp0_rdata, 32'hDEADBEEF);
        tick();
        chk("lb_ready1_14", {31'b0, req1_ready}, 1);
        chk("lb_addr_14", {23'b0, ram_addr}, 14);
        tick();
        req1_addr = 9'd15; req1_wdata = 32'h10F; req1_lock = 1'b0;
        settle();
        chk("lb_ready1_15", {31'b0, req1_ready}, 1);
        chk("lb_addr_15", {23'b0, ram_addr}, 15);
        // reset in the middle of a locked port 0 read burst
        tick();
        req1_valid = 1'b0; req1_we = 1'b0;
        req0_valid = 1'b1; req0_lock = 1'b1; req0_addr = 9'd20;
        settle();
        chk("lb_mem13", mem[13], 32'h10D);
        chk("lb_mem15", mem[15], 32'h10F);
        chk("lb_no_rsp1", {31'b0, rsp1_valid}, 0);
        tick();
        chk("rb_ready0_20", {31'b0, req0_ready}, 1);
        tick();
        req0_addr = 9'd21;
        reset = 1'b1;
        settle();
        chk("rb_ready0_21", {31'b0, req0_ready}, 1);
        tick();
        reset = 1'b0;
        req0_valid = 1'b0; req0_lock = 1'b0;
        settle();
        chk("rb_rsp0_dropped", {31'b0, rsp0_valid}, 0);
        chk("rb_ready0", {31'b0, req0_ready}, 0);
        chk("rb_ram_en", {31'b0, ram_en}, 0);
        tick();
        chk("rb_quiet_en", {31'b0, ram_en}, 0);
        chk("rb_quiet_rsp0", {31'b0, rsp0_valid}, 0);
        req0_valid = 1'b1; req0_addr = 9'd5;
        req1_valid = 1'b1; req1_addr = 9'd6;
        tick();
        chk("rb_prio_ready0", {31'b0, req0_ready}, 1);
        chk("rb_prio_ready1", {31'b0, req1_ready}, 0);
        tick();
        chk("rb_rsp0", {31'b0, rsp0_valid}, 1);
        chk("rb_rdata0", rsp0_rdata, 32'hDEADBEEF);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
